acq_sequencer: RTL and testbench

- Controller for the ADC capture datapath: arms the trigger, gates the waveform generators, and counts the capture window.
- Freezes the captured record and streams it out sample-by-sample to the UART transmit path over a valid/ready handshake.
- Supports continuous, single-shot and auto (forced-trigger on timeout) modes.
- Sits between the trigger/waveform-generator logic and the UART packetiser.

---
 rtl/acq_sequencer.sv | 175 +++++++++++++++++
 tb/tb_acq_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: arms the trigger, times the capture window, then streams
// the frozen record out over a valid/ready handshake before re-arming.
module acq_sequencer #(
  parameter int unsigned SAMPLES      = 1000,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned HOLDOFF      = 16,
  parameter int unsigned AUTO_TIMEOUT = 1000000,
  parameter int unsigned WN_W         = 16
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              single,
  input  logic              auto_en,
  input  logic              trigger,
  output logic              acquire,
  output logic              capture_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_last,
  output logic              forced,
  output logic [WN_W-1:0]   wave_number,
  output logic [2:0]        state
);

  localparam int unsigned TMO_W  = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
  localparam int unsigned HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SAMPLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(AUTO_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_CAPTURE = 3'd2,
    S_READOUT = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  state_t              cur_state;
  state_t              nxt_state;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [TMO_W-1:0]    tmo_nxt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [HOLD_W-1:0]   hold_nxt;
  logic [ADDR_W-1:0]   wr_nxt;
  logic [ADDR_W-1:0]   rd_nxt;
  logic [WN_W-1:0]     wn_nxt;
  logic                forced_nxt;
  logic                xfer;

  assign state = 3'(cur_state);
  assign xfer  = rd_valid & rd_ready;

  // State and counter register
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state   <= S_IDLE;
      tmo_cnt     <= '0;
      hold_cnt    <= '0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      wave_number <= '0;
      forced      <= 1'b0;
    end else begin
      cur_state   <= nxt_state;
      tmo_cnt     <= tmo_nxt;
      hold_cnt    <= hold_nxt;
      wr_addr     <= wr_nxt;
      rd_addr     <= rd_nxt;
      wave_number <= wn_nxt;
      forced      <= forced_nxt;
    end
  end

  // Next-state and counter updates; abort overrides every other event
  always_comb begin
    nxt_state  = cur_state;
    tmo_nxt    = tmo_cnt;
    hold_nxt   = hold_cnt;
    wr_nxt     = wr_addr;
    rd_nxt     = rd_addr;
    wn_nxt     = wave_number;
    forced_nxt = forced;

    if (abort) begin
      nxt_state = S_IDLE;
      tmo_nxt   = '0;
      hold_nxt  = '0;
      wr_nxt    = '0;
      rd_nxt    = '0;
    end else begin
      unique case (cur_state)
        S_IDLE: begin
          if (start) begin
            nxt_state = S_ARMED;
            tmo_nxt   = '0;
          end
        end
        S_ARMED: begin
          // A real trigger wins over a coincident timeout
          if (trigger) begin
            nxt_state  = S_CAPTURE;
            forced_nxt = 1'b0;
            wr_nxt     = '0;
            tmo_nxt    = '0;
          end else if (auto_en) begin
            if (tmo_cnt == TMO_LAST) begin
              nxt_state  = S_CAPTURE;
              forced_nxt = 1'b1;
              wr_nxt     = '0;
              tmo_nxt    = '0;
            end else begin
              tmo_nxt = tmo_cnt + TMO_W'(1);
            end
          end
        end
        S_CAPTURE: begin
          if (wr_addr == LAST_ADDR) begin
            nxt_state = S_READOUT;
            wr_nxt    = '0;
            rd_nxt    = '0;
            wn_nxt    = wave_number + WN_W'(1);
          end else begin
            wr_nxt = wr_addr + ADDR_W'(1);
          end
        end
        S_READOUT: begin
          if (xfer) begin
            if (rd_addr == LAST_ADDR) begin
              nxt_state = single ? S_IDLE : S_HOLDOFF;
              rd_nxt    = '0;
              hold_nxt  = '0;
            end else begin
              rd_nxt = rd_addr + ADDR_W'(1);
            end
          end
        end
        S_HOLDOFF: begin
          if (hold_cnt == HOLD_LAST) begin
            nxt_state = S_ARMED;
            hold_nxt  = '0;
            tmo_nxt   = '0;
          end else begin
            hold_nxt = hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          nxt_state = S_IDLE;
        end
      endcase
    end
  end

  // Status outputs registered from the next state so they align with it
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      acquire    <= 1'b1;
      capture_en <= 1'b0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
    end else begin
      acquire    <= (nxt_state == S_IDLE) || (nxt_state == S_READOUT) ||
                    (nxt_state == S_HOLDOFF);
      capture_en <= (nxt_state == S_CAPTURE);
      rd_valid   <= (nxt_state == S_READOUT);
      rd_last    <= (nxt_state == S_READOUT) && (rd_nxt == LAST_ADDR);
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer: SAMPLES=8, HOLDOFF=16, AUTO_TIMEOUT=20 and a
// 3-bit wave_number so the record counter wraps within a short run.
module tb_acq_sequencer;

  localparam int unsigned SAMPLES      = 8;
  localparam int unsigned ADDR_W       = 4;
  localparam int unsigned HOLDOFF      = 16;
  localparam int unsigned AUTO_TIMEOUT = 20;
  localparam int unsigned WN_W         = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start, abort, single, auto_en, trigger, rd_ready;
  logic              acquire, capture_en, rd_valid, rd_last, forced;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [WN_W-1:0]   wave_number;
  logic [2:0]        state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  acq_sequencer #(
    .SAMPLES(SAMPLES), .ADDR_W(ADDR_W), .HOLDOFF(HOLDOFF),
    .AUTO_TIMEOUT(AUTO_TIMEOUT), .WN_W(WN_W)
  ) dut (
    .sys_clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .single(single), .auto_en(auto_en), .trigger(trigger),
    .acquire(acquire), .capture_en(capture_en), .wr_addr(wr_addr),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_last(rd_last), .forced(forced), .wave_number(wave_number),
    .state(state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One single-shot record from IDLE back to IDLE
  task automatic run_single(input logic [31:0] exp_wn);
    start = 1'b1; tick(); start = 1'b0;
    chk("single_armed", 32'(state), 32'd1);
    trigger = 1'b1; tick(); trigger = 1'b0;
    chk("single_capture", 32'(state), 32'd2);
    repeat (SAMPLES) tick();
    chk("single_readout", 32'(state), 32'd3);
    chk("single_wn", 32'(wave_number), exp_wn);
    rd_ready = 1'b1; repeat (SAMPLES) tick(); rd_ready = 1'b0;
    chk("single_idle", 32'(state), 32'd0);
    chk("single_rd_valid", 32'(rd_valid), 32'd0);
  endtask

  initial begin
    int exp_addr;
    int xfers;
    logic rdy;

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; single = 1'b0;
    auto_en = 1'b0; trigger = 1'b0; rd_ready = 1'b0;
    tick(); tick();

    // Reset values
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_acquire", 32'(acquire), 32'd1);
    chk("rst_wn", 32'(wave_number), 32'd0);
    chk("rst_forced", 32'(forced), 32'd0);
    chk("rst_capture_en", 32'(capture_en), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_last", 32'(rd_last), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    reset_n = 1'b1;
    tick();
    trigger = 1'b1; rd_ready = 1'b1; tick(); trigger = 1'b0; rd_ready = 1'b0;
    chk("idle_ignores_trigger", 32'(state), 32'd0);

    // Continuous record with triggered capture and full-rate readout
    start = 1'b1; tick(); start = 1'b0;
    chk("a_armed", 32'(state), 32'd1);
    chk("a_acquire_armed", 32'(acquire), 32'd0);
    repeat (4) tick();
    trigger = 1'b1; tick(); trigger = 1'b0;
    chk("a_forced", 32'(forced), 32'd0);
    for (int i = 0; i < SAMPLES; i++) begin
      chk("a_cap_state", 32'(state), 32'd2);
      chk("a_capture_en", 32'(capture_en), 32'd1);
      chk("a_wr_addr", 32'(wr_addr), 32'(i));
      if (i == 3) begin
        trigger = 1'b1; start = 1'b1;
      end else begin
        trigger = 1'b0; start = 1'b0;
      end
      tick();
    end
    trigger = 1'b0; start = 1'b0;
    chk("a_readout", 32'(state), 32'd3);
    chk("a_capture_off", 32'(capture_en), 32'd0);
    chk("a_wr_addr_zero", 32'(wr_addr), 32'd0);
    chk("a_wn", 32'(wave_number), 32'd1);
    chk("a_acquire_ro", 32'(acquire), 32'd1);
    rd_ready = 1'b1;
    for (int i = 0; i < SAMPLES; i++) begin
      chk("a_rd_valid", 32'(rd_valid), 32'd1);
      chk("a_rd_addr", 32'(rd_addr), 32'(i));
      chk("a_rd_last", 32'(rd_last), (i == SAMPLES - 1) ? 32'd1 : 32'd0);
      tick();
    end
    rd_ready = 1'b0;
    chk("a_rd_valid_drop", 32'(rd_valid), 32'd0);
    chk("a_rd_addr_reset", 32'(rd_addr), 32'd0);
    for (int j = 0; j < HOLDOFF; j++) begin
      chk("a_holdoff", 32'(state), 32'd4);
      if (j == 5) trigger = 1'b1; else trigger = 1'b0;
      tick();
    end
    trigger = 1'b0;
    chk("a_rearmed", 32'(state), 32'd1);

    // Readout under a stalling rd_ready pattern
    trigger = 1'b1; tick(); trigger = 1'b0;
    repeat (SAMPLES) tick();
    chk("b_readout", 32'(state), 32'd3);
    chk("b_wn", 32'(wave_number), 32'd2);
    exp_addr = 0;
    xfers = 0;
    for (int c = 0; c < 200 && xfers < SAMPLES; c++) begin
      case (c)
        0: rdy = 1'b1;
        1: rdy = 1'b0;
        2: rdy = 1'b0;
        3: rdy = 1'b1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      rd_ready = rdy;
      chk("b_rd_valid", 32'(rd_valid), 32'd1);
      chk("b_rd_addr", 32'(rd_addr), 32'(exp_addr));
      chk("b_rd_last", 32'(rd_last), (exp_addr == SAMPLES - 1) ? 32'd1 : 32'd0);
      tick();
      if (rdy) begin
        exp_addr++;
        xfers++;
      end
    end
    rd_ready = 1'b0;
    chk("b_xfers", 32'(xfers), 32'(SAMPLES));
    chk("b_holdoff", 32'(state), 32'd4);
    chk("b_rd_valid_drop", 32'(rd_valid), 32'd0);
    repeat (HOLDOFF) tick();
    chk("b_rearmed", 32'(state), 32'd1);

    // Auto-forced capture after the timeout
    auto_en = 1'b1;
    for (int k = 0; k < AUTO_TIMEOUT; k++) begin
      chk("c_waiting", 32'(state), 32'd1);
      tick();
    end
    chk("c_forced_capture", 32'(state), 32'd2);
    chk("c_forced", 32'(forced), 32'd1);
    repeat (SAMPLES) tick();
    chk("c_wn", 32'(wave_number), 32'd3);
    chk("c_forced_held", 32'(forced), 32'd1);
    rd_ready = 1'b1; repeat (SAMPLES) tick(); rd_ready = 1'b0;
    repeat (HOLDOFF) tick();
    chk("c_rearmed", 32'(state), 32'd1);
    // Trigger coinciding with the timeout is a real trigger
    repeat (AUTO_TIMEOUT - 1) tick();
    chk("c2_still_armed", 32'(state), 32'd1);
    trigger = 1'b1; tick(); trigger = 1'b0;
    chk("c2_capture", 32'(state), 32'd2);
    chk("c2_forced", 32'(forced), 32'd0);
    auto_en = 1'b0;
    repeat (SAMPLES) tick();
    chk("c2_wn", 32'(wave_number), 32'd4);
    rd_ready = 1'b1; repeat (SAMPLES) tick(); rd_ready = 1'b0;
    repeat (HOLDOFF) tick();
    chk("c2_rearmed", 32'(state), 32'd1);

    // Abort mid-capture with a simultaneous trigger
    trigger = 1'b1; tick(); trigger = 1'b0;
    repeat (3) tick();
    chk("d_wr_addr3", 32'(wr_addr), 32'd3);
    abort = 1'b1; trigger = 1'b1; tick(); abort = 1'b0; trigger = 1'b0;
    chk("d_idle", 32'(state), 32'd0);
    chk("d_capture_off", 32'(capture_en), 32'd0);
    chk("d_wr_addr", 32'(wr_addr), 32'd0);
    chk("d_wn", 32'(wave_number), 32'd4);
    chk("d_acquire", 32'(acquire), 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    trigger = 1'b1; tick(); trigger = 1'b0;
    chk("d_recapture", 32'(state), 32'd2);
    chk("d_recapture_addr", 32'(wr_addr), 32'd0);
    repeat (SAMPLES) tick();
    chk("d_wn_after", 32'(wave_number), 32'd5);

    // Single mode sampled at the last transfer, then wrap of wave_number
    single = 1'b1;
    rd_ready = 1'b1; repeat (SAMPLES) tick(); rd_ready = 1'b0;
    chk("e_idle", 32'(state), 32'd0);
    chk("e_wn", 32'(wave_number), 32'd5);
    run_single(32'd6);
    run_single(32'd7);
    run_single(32'd0);

    // Asynchronous reset in the middle of a capture
    start = 1'b1; tick(); start = 1'b0;
    trigger = 1'b1; tick(); trigger = 1'b0;
    repeat (4) tick();
    chk("f_wr_addr4", 32'(wr_addr), 32'd4);
    #2 reset_n = 1'b0;
    #1;
    chk("f_state", 32'(state), 32'd0);
    chk("f_acquire", 32'(acquire), 32'd1);
    chk("f_wn", 32'(wave_number), 32'd0);
    chk("f_capture_en", 32'(capture_en), 32'd0);
    chk("f_wr_addr", 32'(wr_addr), 32'd0);
    reset_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
